// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared constants, state/mode types and sprite geometry for the tile drawer
package draw_pkg;

    localparam int POS_WALL  = 7;
    localparam int POS_TANK1 = 6;
    localparam int POS_TANK2 = 5;
    localparam int POS_PROJ  = 4;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [2:0] COL_WALL_DEF   = 3'b011;
    localparam logic [2:0] COL_TANK1_DEF  = 3'b101;
    localparam logic [2:0] COL_TANK2_DEF  = 3'b100;
    localparam logic [2:0] COL_BARREL_DEF = 3'b111;
    localparam logic [2:0] COL_PROJ_DEF   = 3'b110;
    localparam logic [2:0] COL_ERASE_DEF  = 3'b000;

    // Sprite offsets/sizes are in pixels relative to the tile origin.
    localparam int SPR_W = 8;
    localparam logic [SPR_W-1:0] BODY_OX   = 8'd4;
    localparam logic [SPR_W-1:0] BODY_OY   = 8'd2;
    localparam logic [SPR_W-1:0] BODY_W    = 8'd8;
    localparam logic [SPR_W-1:0] BODY_H    = 8'd8;
    localparam logic [SPR_W-1:0] BARREL_W  = 8'd2;
    localparam logic [SPR_W-1:0] BARREL_H  = 8'd2;
    localparam logic [SPR_W-1:0] PROJ_OX   = 8'd7;
    localparam logic [SPR_W-1:0] PROJ_OY   = 8'd5;
    localparam logic [SPR_W-1:0] PROJ_W    = 8'd2;
    localparam logic [SPR_W-1:0] PROJ_H    = 8'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_BARREL,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        M_ERASE,
        M_WALL,
        M_TANK1,
        M_TANK2,
        M_PROJ
    } mode_t;

    function automatic mode_t decode_mode(input logic [7:0] pos);
        mode_t m;
        if (pos[POS_WALL])       m = M_WALL;
        else if (pos[POS_TANK1]) m = M_TANK1;
        else if (pos[POS_TANK2]) m = M_TANK2;
        else if (pos[POS_PROJ])  m = M_PROJ;
        else                     m = M_ERASE;
        return m;
    endfunction

    function automatic logic [SPR_W-1:0] barrel_ox(input logic [1:0] dir);
        logic [SPR_W-1:0] v;
        case (dir)
            DIR_UP:    v = 8'd7;
            DIR_DOWN:  v = 8'd7;
            DIR_RIGHT: v = 8'd12;
            default:   v = 8'd2;
        endcase
        return v;
    endfunction

    function automatic logic [SPR_W-1:0] barrel_oy(input logic [1:0] dir);
        logic [SPR_W-1:0] v;
        case (dir)
            DIR_UP:    v = 8'd0;
            DIR_DOWN:  v = 8'd10;
            DIR_RIGHT: v = 8'd5;
            default:   v = 8'd5;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tile_scan_counter.sv
// rtl/tile_scan_counter.sv - row-major 2-D scan counter with clear, enable and last flag
module tile_scan_counter #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] w,
    input  logic [CW-1:0] h,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic          last
);

    logic [CW-1:0] cx_q, cx_d;
    logic [CW-1:0] cy_q, cy_d;
    logic          x_end, y_end;

    assign x_end = (cx_q == (w - CW'(1)));
    assign y_end = (cy_q == (h - CW'(1)));
    assign last  = x_end && y_end;
    assign cx    = cx_q;
    assign cy    = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clr) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en) begin
            if (x_end) begin
                cx_d = '0;
                cy_d = y_end ? '0 : cy_q + CW'(1);
            end else begin
                cx_d = cx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/tile_sprite_drawer.sv
// rtl/tile_sprite_drawer.sv - draws one framebuffer tile (wall, tank with barrel, projectile or erase)
module tile_sprite_drawer
    import draw_pkg::*;
#(
    parameter int         TILE_W     = 16,
    parameter int         TILE_H     = 12,
    parameter int         X_W        = 8,
    parameter int         Y_W        = 8,
    parameter logic [2:0] COL_WALL   = COL_WALL_DEF,
    parameter logic [2:0] COL_TANK1  = COL_TANK1_DEF,
    parameter logic [2:0] COL_TANK2  = COL_TANK2_DEF,
    parameter logic [2:0] COL_BARREL = COL_BARREL_DEF,
    parameter logic [2:0] COL_PROJ   = COL_PROJ_DEF,
    parameter logic [2:0] COL_ERASE  = COL_ERASE_DEF
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic [7:0]     address,
    input  logic [7:0]     position,
    output logic           busy,
    output logic           done,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour
);

    localparam int CW = SPR_W;

    state_t         state_q;
    mode_t          mode_q;
    logic [1:0]     dir_q;
    logic [7:0]     addr_q;
    logic           busy_q, done_q, plot_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [2:0]     colour_q;

    logic [CW-1:0]  seg_ox, seg_oy, seg_w, seg_h;
    logic [2:0]     seg_col;
    logic [CW-1:0]  cx, cy, ox, oy;
    logic           cnt_last, cnt_clr, cnt_en, in_tile, is_tank;
    logic [X_W+3:0] bx;
    logic [Y_W+3:0] by;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;

    assign is_tank = (mode_q == M_TANK1) || (mode_q == M_TANK2);

    // Geometry of the segment currently being scanned; BARREL always follows a tank body.
    always_comb begin
        seg_ox  = '0;
        seg_oy  = '0;
        seg_w   = CW'(TILE_W);
        seg_h   = CW'(TILE_H);
        seg_col = COL_ERASE;
        if (state_q == S_BARREL) begin
            seg_ox  = barrel_ox(dir_q);
            seg_oy  = barrel_oy(dir_q);
            seg_w   = BARREL_W;
            seg_h   = BARREL_H;
            seg_col = COL_BARREL;
        end else begin
            case (mode_q)
                M_WALL: seg_col = COL_WALL;
                M_TANK1, M_TANK2: begin
                    seg_ox  = BODY_OX;
                    seg_oy  = BODY_OY;
                    seg_w   = BODY_W;
                    seg_h   = BODY_H;
                    seg_col = (mode_q == M_TANK1) ? COL_TANK1 : COL_TANK2;
                end
                M_PROJ: begin
                    seg_ox  = PROJ_OX;
                    seg_oy  = PROJ_OY;
                    seg_w   = PROJ_W;
                    seg_h   = PROJ_H;
                    seg_col = COL_PROJ;
                end
                default: seg_col = COL_ERASE;
            endcase
        end
    end

    assign cnt_en  = (state_q == S_BODY) || (state_q == S_BARREL);
    assign cnt_clr = (state_q == S_IDLE) || ((state_q == S_BODY) && cnt_last);

    tile_scan_counter #(
        .CW (CW)
    ) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .w      (seg_w),
        .h      (seg_h),
        .cx     (cx),
        .cy     (cy),
        .last   (cnt_last)
    );

    assign ox      = seg_ox + cx;
    assign oy      = seg_oy + cy;
    assign in_tile = (32'(ox) < TILE_W) && (32'(oy) < TILE_H);

    // Origin is formed wide and then wrapped to the output width.
    assign bx  = (X_W+4)'(addr_q[3:0]) * (X_W+4)'(TILE_W);
    assign by  = (Y_W+4)'(addr_q[7:4]) * (Y_W+4)'(TILE_H);
    assign x_d = X_W'(bx + (X_W+4)'(ox));
    assign y_d = Y_W'(by + (Y_W+4)'(oy));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            mode_q   <= M_ERASE;
            dir_q    <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            done_q <= 1'b0;
            plot_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= address;
                        mode_q  <= decode_mode(position);
                        dir_q   <= position[1:0];
                        busy_q  <= 1'b1;
                        state_q <= S_BODY;
                    end
                end
                S_BODY, S_BARREL: begin
                    plot_q <= in_tile;
                    if (in_tile) begin
                        x_q      <= x_d;
                        y_q      <= y_d;
                        colour_q <= seg_col;
                    end
                    if (cnt_last) begin
                        state_q <= ((state_q == S_BODY) && is_tank) ? S_BARREL : S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_tile_sprite_drawer.sv
// tb/tb_tile_sprite_drawer.sv - directed self-checking bench for tile_sprite_drawer
module tb_tile_sprite_drawer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] position = 8'h00;
    logic       busy, done, plot;
    logic [7:0] x, y;
    logic [2:0] colour;

    tile_sprite_drawer dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .address  (address),
        .position (position),
        .busy     (busy),
        .done     (done),
        .plot     (plot),
        .x        (x),
        .y        (y),
        .colour   (colour)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    int px[$], py[$], pc[$];
    int ex[$], ey[$], ec[$];
    int first_plot_cyc, done_cnt, done_prev_plot, done_busy, busy_bad, gap_bad, timed_out, busy_at_accept;

    task automatic clear_expect();
        ex.delete(); ey.delete(); ec.delete();
    endtask

    task automatic add_rect(input int bx, input int by, input int ox, input int oy,
                            input int w, input int h, input int c);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                ex.push_back((bx + ox + i) % 256);
                ey.push_back((by + oy + j) % 256);
                ec.push_back(c);
            end
    endtask

    // Issues one start and records every plotted pixel until done, then watches a few idle cycles.
    task automatic run_draw(input logic [7:0] a, input logic [7:0] p, input int pulse_at);
        int prev;
        prev = 0;
        px.delete(); py.delete(); pc.delete();
        first_plot_cyc = -1; done_cnt = 0; done_prev_plot = 0; done_busy = 1;
        busy_bad = 0; gap_bad = 0; timed_out = 1;
        @(negedge clock);
        address = a; position = p; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        busy_at_accept = busy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            if (plot) begin
                if (first_plot_cyc < 0) first_plot_cyc = cyc;
                if (prev == 0 && px.size() > 0) gap_bad++;
                if (!busy) busy_bad++;
                px.push_back(x); py.push_back(y); pc.push_back(colour);
            end
            start = (pulse_at >= 0 && plot && px.size() == pulse_at);
            if (pulse_at >= 0 && start) position = 8'h80;
            if (done) begin
                done_cnt++; done_prev_plot = prev; done_busy = busy; timed_out = 0;
                break;
            end
            prev = plot;
        end
        start = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done) done_cnt++;
            if (plot) begin
                px.push_back(x); py.push_back(y); pc.push_back(colour);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        #2;
        checks++;
        if ({busy, done, plot, x, y, colour} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%0b done=%0b plot=%0b x=%0d y=%0d col=%0d want all 0",
                     busy, done, plot, x, y, colour);
        end
        @(negedge clock); @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        address = 8'h21; position = 8'h80; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 300 && n < 50; cyc++) begin
            @(negedge clock);
            if (plot) n++;
        end
        checks++;
        if (n != 50) begin
            failures++;
            $display("FAIL reset_reach50 got %0d plots want 50", n);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, plot, x, y, colour} !== 22'd0) begin
            failures++;
            $display("FAIL reset_abort got busy=%0b done=%0b plot=%0b x=%0d y=%0d col=%0d want all 0",
                     busy, done, plot, x, y, colour);
        end
        @(negedge clock);
        resetn = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clock);
            if (done || plot || busy) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL reset_no_stale got %0d active cycles want 0", n);
        end
        run_draw(8'h21, 8'h80, -1);
        checks++;
        if (px.size() != 192 || done_cnt != 1) begin
            failures++;
            $display("FAIL reset_fresh_draw got plots=%0d done=%0d want 192/1", px.size(), done_cnt);
        end
    endtask

    task automatic test_wall();
        int bad;
        clear_expect();
        add_rect(16, 24, 0, 0, 16, 12, 3);
        run_draw(8'h21, 8'h80, -1);
        checks++;
        if (px.size() != 192) begin
            failures++;
            $display("FAIL wall_count got %0d want 192", px.size());
        end
        bad = -1;
        for (int i = 0; i < ex.size() && i < px.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i]) begin bad = i; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL wall_pixels idx=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     bad, px[bad], py[bad], pc[bad], ex[bad], ey[bad], ec[bad]);
        end
        checks++;
        if (first_plot_cyc != 0 || busy_at_accept != 1) begin
            failures++;
            $display("FAIL wall_latency got first=%0d busy=%0d want 0/1", first_plot_cyc, busy_at_accept);
        end
        checks++;
        if (timed_out != 0 || done_prev_plot != 1 || done_cnt != 1 || done_busy != 0) begin
            failures++;
            $display("FAIL wall_done got timeout=%0d prev_plot=%0d pulses=%0d busy=%0d want 0/1/1/0",
                     timed_out, done_prev_plot, done_cnt, done_busy);
        end
        checks++;
        if (busy_bad != 0 || gap_bad != 0) begin
            failures++;
            $display("FAIL wall_busy_gap got busy_bad=%0d gaps=%0d want 0/0", busy_bad, gap_bad);
        end
    endtask

    task automatic test_tank1_right();
        int bad;
        clear_expect();
        add_rect(0, 0, 4, 2, 8, 8, 5);
        add_rect(0, 0, 12, 5, 2, 2, 7);
        run_draw(8'h00, 8'h42, -1);
        checks++;
        if (px.size() != 68 || gap_bad != 0) begin
            failures++;
            $display("FAIL tank1_count got %0d gaps=%0d want 68/0", px.size(), gap_bad);
        end
        bad = -1;
        for (int i = 0; i < ex.size() && i < px.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i]) begin bad = i; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL tank1_pixels idx=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     bad, px[bad], py[bad], pc[bad], ex[bad], ey[bad], ec[bad]);
        end
    endtask

    task automatic test_tank2_up();
        int bad;
        clear_expect();
        add_rect(0, 0, 4, 2, 8, 8, 4);
        add_rect(0, 0, 7, 0, 2, 2, 7);
        run_draw(8'h00, 8'h30, -1);
        checks++;
        if (px.size() != 68 || done_cnt != 1) begin
            failures++;
            $display("FAIL tank2_count got %0d done=%0d want 68/1", px.size(), done_cnt);
        end
        bad = -1;
        for (int i = 0; i < ex.size() && i < px.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i]) begin bad = i; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL tank2_pixels idx=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     bad, px[bad], py[bad], pc[bad], ex[bad], ey[bad], ec[bad]);
        end
    endtask

    task automatic test_tank_left_priority();
        int bad;
        clear_expect();
        add_rect(112, 48, 4, 2, 8, 8, 5);
        add_rect(112, 48, 2, 5, 2, 2, 7);
        run_draw(8'h47, 8'h63, -1);
        bad = (px.size() != 68) ? 0 : -1;
        for (int i = 0; bad < 0 && i < ex.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL tank_left_pixels idx=%0d count=%0d want 68 plots of tank1 body + left barrel",
                     bad, px.size());
        end
    endtask

    task automatic test_proj_busy();
        int bad;
        clear_expect();
        add_rect(240, 180, 7, 5, 2, 2, 6);
        run_draw(8'hFF, 8'h10, 2);
        checks++;
        if (px.size() != 4) begin
            failures++;
            $display("FAIL proj_count got %0d want 4", px.size());
        end
        bad = -1;
        for (int i = 0; i < ex.size() && i < px.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i]) begin bad = i; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL proj_pixels idx=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     bad, px[bad], py[bad], pc[bad], ex[bad], ey[bad], ec[bad]);
        end
        checks++;
        if (done_busy != 0 || done_cnt != 1 || done_prev_plot != 1) begin
            failures++;
            $display("FAIL proj_done got busy=%0d pulses=%0d prev_plot=%0d want 0/1/1",
                     done_busy, done_cnt, done_prev_plot);
        end
    endtask

    task automatic test_erase();
        int bad;
        clear_expect();
        add_rect(240, 132, 0, 0, 16, 12, 0);
        run_draw(8'hBF, 8'h00, -1);
        checks++;
        if (px.size() != 192) begin
            failures++;
            $display("FAIL erase_count got %0d want 192", px.size());
        end
        bad = -1;
        for (int i = 0; i < ex.size() && i < px.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i]) begin bad = i; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL erase_pixels idx=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     bad, px[bad], py[bad], pc[bad], ex[bad], ey[bad], ec[bad]);
        end
        checks++;
        if (x !== 8'd255 || y !== 8'd143 || colour !== 3'b000) begin
            failures++;
            $display("FAIL erase_hold got x=%0d y=%0d col=%0d want 255/143/0", x, y, colour);
        end
    endtask

    initial begin
        test_reset();
        test_wall();
        test_tank1_right();
        test_tank2_up();
        test_tank_left_priority();
        test_proj_busy();
        test_erase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
